// File: rtl/gemm_pkg.sv
// Shared types and sizing helpers for the GEMM tile sequencer.
package gemm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } gemm_seq_state_t;

    // Width of an index or address covering n locations; a single location still gets one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_M = 4;
    localparam int DEF_N = 4;
    localparam int DEF_K = 4;

    localparam int DEF_A_ADDR_W = addr_w(DEF_M * DEF_K);
    localparam int DEF_B_ADDR_W = addr_w(DEF_K * DEF_N);
    localparam int DEF_C_ADDR_W = addr_w(DEF_M * DEF_N);

endpackage

// File: rtl/gemm_tile_seq_mac.sv
// Registered multiply-accumulate stage: sum <= cur_sum + a*b, wrapping at DATA_WIDTH.
module mac_unit #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] cur_sum,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum
);

    logic signed [DATA_WIDTH-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else if (en) begin
            sum <= cur_sum + prod;
        end
    end

endmodule

// File: rtl/gemm_tile_seq.sv
// GEMM tile sequencer: streams A/B operands through one MAC and writes C row-major.
module gemm_tile_seq
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = DEF_M,
    parameter int MATRIX_WIDTH  = DEF_N,
    parameter int MATRIX_ADJUST = DEF_K,
    localparam int AAW = addr_w(MATRIX_HEIGHT * MATRIX_ADJUST),
    localparam int BAW = addr_w(MATRIX_ADJUST * MATRIX_WIDTH),
    localparam int CAW = addr_w(MATRIX_HEIGHT * MATRIX_WIDTH)
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic                         istart,
    output logic                         obusy,
    output logic                         odone,
    output logic                         oa_re,
    output logic [AAW-1:0]               oa_addr,
    input  logic signed [DATA_WIDTH-1:0] ia_data,
    output logic                         ob_re,
    output logic [BAW-1:0]               ob_addr,
    input  logic signed [DATA_WIDTH-1:0] ib_data,
    output logic                         oc_we,
    output logic [CAW-1:0]               oc_addr,
    output logic [DATA_WIDTH-1:0]        oc_data
);

    localparam int IW = addr_w(MATRIX_HEIGHT);
    localparam int JW = addr_w(MATRIX_WIDTH);
    localparam int KW = addr_w(MATRIX_ADJUST);

    gemm_seq_state_t state, state_next;

    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic [KW-1:0] k;
    logic          drain_ph;
    logic          op_valid;
    logic          op_first;
    logic          i_last, j_last, k_last;

    logic signed [DATA_WIDTH-1:0] mac_sum;
    logic signed [DATA_WIDTH-1:0] cur_sum;

    assign i_last = (i == IW'(MATRIX_HEIGHT - 1));
    assign j_last = (j == JW'(MATRIX_WIDTH - 1));
    assign k_last = (k == KW'(MATRIX_ADJUST - 1));

    // Read data lands one cycle after issue; the k=0 pair starts a fresh sum.
    assign cur_sum = op_first ? '0 : mac_sum;

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mac (
        .clk    (iclk),
        .rst    (irst),
        .en     (op_valid),
        .cur_sum(cur_sum),
        .a      (ia_data),
        .b      (ib_data),
        .sum    (mac_sum)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            drain_ph <= 1'b0;
            op_valid <= 1'b0;
            op_first <= 1'b0;
        end else begin
            op_valid <= (state == FETCH);
            op_first <= (state == FETCH) && (k == '0);
            drain_ph <= (state == DRAIN) && !drain_ph;
            case (state)
                IDLE: begin
                    if (istart) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                FETCH: begin
                    if (!k_last) begin
                        k <= k + KW'(1);
                    end
                end
                WRITE: begin
                    k <= '0;
                    if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + IW'(1);
                    end else begin
                        j <= j + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        obusy      = 1'b0;
        odone      = 1'b0;
        oa_re      = 1'b0;
        ob_re      = 1'b0;
        oc_we      = 1'b0;
        oa_addr    = '0;
        ob_addr    = '0;
        oc_addr    = '0;
        oc_data    = '0;
        case (state)
            IDLE: begin
                if (istart) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                obusy   = 1'b1;
                oa_re   = 1'b1;
                ob_re   = 1'b1;
                oa_addr = AAW'(i) * AAW'(MATRIX_ADJUST) + AAW'(k);
                ob_addr = BAW'(k) * BAW'(MATRIX_WIDTH) + BAW'(j);
                if (k_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                obusy = 1'b1;
                if (drain_ph) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                obusy   = 1'b1;
                oc_we   = 1'b1;
                oc_addr = CAW'(i) * CAW'(MATRIX_WIDTH) + CAW'(j);
                oc_data = mac_sum;
                state_next = (i_last && j_last) ? DONE : FETCH;
            end
            DONE: begin
                obusy      = 1'b1;
                odone      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
